// File: rtl/fpu_input_queue.sv
// rtl/fpu_input_queue.sv - elastic operand decode queue ahead of the FPU datapath
// Decodes IEEE-754 operand pairs on entry and buffers them in a DEPTH-entry FIFO.
module fpu_input_queue #(
  parameter int REG_SIZE = 64,
  parameter int INT_OUT  = 53,
  parameter int EXP_OUT  = 11,
  parameter int OP_BITS  = 2,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_SIZE-1:0]      inpA,
  input  logic [REG_SIZE-1:0]      inpB,
  input  logic [OP_BITS-1:0]       operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_OUT-1:0]       outA,
  output logic [INT_OUT-1:0]       outB,
  output logic [EXP_OUT-1:0]       expA,
  output logic [EXP_OUT-1:0]       expB,
  output logic                     signA,
  output logic                     signB,
  output logic [2:0]               flagsA,
  output logic [2:0]               flagsB,
  output logic                     denA,
  output logic                     denB,
  output logic [OP_BITS-1:0]       op,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int HW = INT_OUT + EXP_OUT + 5;
  localparam int EW = 2 * HW + OP_BITS;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Half entry layout: {mantissa, exponent, sign, {nan, inf, zero}, den}
  function automatic logic [HW-1:0] decode(input logic [REG_SIZE-1:0] x, input logic dbl);
    logic [10:0]        e;
    logic [51:0]        f;
    logic               eMax;
    logic               eZero;
    logic               fZero;
    logic               s;
    logic [EXP_OUT-1:0] ex;
    logic [INT_OUT-1:0] m;
    if (dbl) begin
      s    = x[63];
      e    = x[62:52];
      f    = x[51:0];
      eMax = &x[62:52];
    end else begin
      s    = x[31];
      e    = {3'b000, x[30:23]};
      f    = {29'b0, x[22:0]};
      eMax = &x[30:23];
    end
    eZero = (e == '0);
    fZero = (f == '0);
    ex = EXP_OUT'(e);
    if (eZero && !fZero) ex = EXP_OUT'(1);
    if (dbl) m = INT_OUT'({!eZero, x[51:0]});
    else     m = INT_OUT'({!eZero, x[22:0]});
    return {m, ex, s, {eMax && !fZero, eMax && fZero, eZero && fZero}, eZero && !fZero};
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [LW-1:0] count;
  logic [EW-1:0] wrData;
  logic          push, pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;
  assign wrData    = {decode(inpA, operation[OP_BITS-1]), decode(inpB, operation[OP_BITS-1]), operation};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left intact; only the bookkeeping is cleared.
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {outA, expA, signA, flagsA, denA, outB, expB, signB, flagsB, denB, op} = mem[rdPtr];

endmodule
